// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling 8N1 UART receiver fed by the baud divider.
// baud_clk is only edge-detected into a one-cycle tick; everything runs on clk_in.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | line idle, waiting for a tick with rx_s low
// START   | counting to mid start bit to reject glitches
// DATA    | sampling DATA_BITS data bits at mid-bit, LSB first
// PARITY  | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP    | sampling the stop bit, deciding valid / error
// BREAK   | stop bit was low; wait for the line to return high
module uart_rx_oversampled #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q;
  logic [TW-1:0]          tick_cnt_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   perr_q;
  logic                   baud_q;
  logic                   rx_meta_q;
  logic                   rx_s_q;
  logic                   tick;
  logic                   par_bad;

`ifdef UART_RX_PARITY_EN
  logic                   par_q;

  // Capture the received parity bit while in PARITY.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (tick && state_q == S_PARITY && tick_cnt_q == TICK_LAST) begin
      par_q <= rx_s_q;
    end
  end

  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = (^shift_q) ^ par_q;
`else
  assign par_bad = 1'b0;
`endif

  // Rising edge of the divided clock becomes a single-cycle tick.
  assign tick = baud_clk & ~baud_q;

  // Baud edge-detect register and two-flop rx synchronizer (idle high).
  always_ff @(posedge clk_in) begin
    if (reset) begin
      baud_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      baud_q    <= baud_clk;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM; counters only advance on ticks, pulses last one cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s_q) begin
              state_q    <= S_START;
              tick_cnt_q <= '0;
            end
          end
          S_START: begin
            if (tick_cnt_q == TICK_MID) begin
              tick_cnt_q <= '0;
              if (!rx_s_q) begin
                state_q   <= S_DATA;
                bit_cnt_q <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
          S_DATA: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              bit_cnt_q  <= bit_cnt_q + BW'(1);
              if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              state_q    <= S_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
`endif
          S_STOP: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              if (rx_s_q) begin
                state_q <= S_IDLE;
                if (par_bad) begin
                  perr_q <= 1'b1;
                end else begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end
              end else begin
                ferr_q  <= 1'b1;
                state_q <= S_BREAK;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
          S_BREAK: begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign data_out      = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign parity_error  = perr_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: directed frames push expected
// events; a monitor pops one per output pulse and compares kind and data.
module tb_uart_rx_oversampled;

  localparam int BIT = 512;  // clk_in cycles per bit (tick every 32, 16 ticks/bit)

  localparam logic [2:0] EV_VALID = 3'b001;
  localparam logic [2:0] EV_FERR  = 3'b010;
  localparam logic [2:0] EV_PERR  = 3'b100;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       baud_clk = 1'b0;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int div_cnt = 0;
  ev_t exp_q[$];
  int  v_cyc[$];
`ifdef UART_RX_PARITY_EN
  logic flip_par = 1'b0;
`endif

  uart_rx_oversampled #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .baud_clk      (baud_clk),
    .rx            (rx),
    .data_out      (data_out),
    .valid         (valid),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  always #5 clk_in = ~clk_in;

  // Baud divider model: BAUD_DIV=16, so baud_clk rises every 32 clk_in.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (div_cnt == 15) begin
      div_cnt  <= 0;
      baud_clk <= ~baud_clk;
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse consumes one expected event.
  always @(negedge clk_in) begin
    if (!reset && (valid || framing_error || parity_error)) begin
      if (valid) v_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got kind=%b data=0x%0h expected no pulse",
                 {parity_error, framing_error, valid}, data_out);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_kind", {29'd0, parity_error, framing_error, valid}, {29'd0, e.kind});
        check("ev_data", {24'd0, data_out}, {24'd0, e.data});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Start bit, data LSB first, optional parity, stop bit; rx left at stop value.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ flip_par;
    wait_cyc(BIT);
`endif
    rx = stop_b;
    wait_cyc(BIT);
  endtask

  initial begin
    logic [7:0] v5a;
    reset = 1'b1;
    rx    = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(1);
    check("rst_data",  {24'd0, data_out}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr",  {31'd0, framing_error}, 32'd0);
    check("rst_perr",  {31'd0, parity_error}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    wait_cyc(BIT);

    // Plain frame 0xA5
    exp_q.push_back('{EV_VALID, 8'hA5});
    send_frame(8'hA5, 1'b1);
    wait_cyc(BIT);
    check("a5_busy", {31'd0, busy}, 32'd0);
    check("a5_pending", exp_q.size(), 32'd0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    v_cyc.delete();
    exp_q.push_back('{EV_VALID, 8'h00});
    exp_q.push_back('{EV_VALID, 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(BIT);
    check("b2b_pending", exp_q.size(), 32'd0);
    check("b2b_count", v_cyc.size(), 32'd2);
    if (v_cyc.size() == 2) begin
      int gap;
      gap = v_cyc[1] - v_cyc[0];
      check("b2b_spacing", {31'd0, (gap >= 10*BIT - 32) && (gap <= 10*BIT + 32)}, 32'd1);
    end
    check("b2b_data", {24'd0, data_out}, 32'hFF);

    // Glitch: 4 ticks low
    rx = 1'b0;
    wait_cyc(100);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    wait_cyc(28);
    rx = 1'b1;
    wait_cyc(384);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_data", {24'd0, data_out}, 32'hFF);

    // Framing error: 0x3C with stop low, then line held low 3 bit periods
    exp_q.push_back('{EV_FERR, 8'hFF});
    send_frame(8'h3C, 1'b0);
    wait_cyc(3*BIT);
    check("brk_busy", {31'd0, busy}, 32'd1);
    check("brk_pending", exp_q.size(), 32'd0);
    rx = 1'b1;
    wait_cyc(2*BIT);
    check("brk_busy_lo", {31'd0, busy}, 32'd0);
    check("brk_data", {24'd0, data_out}, 32'hFF);

    // Reset during bit 4 of 0x5A, then 0x81
    v5a = 8'h5A;
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = v5a[i];
      wait_cyc(BIT);
    end
    rx = v5a[4];
    wait_cyc(BIT/2);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    rx = 1'b1;
    wait_cyc(1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data", {24'd0, data_out}, 32'h0);
    wait_cyc(2*BIT);
    exp_q.push_back('{EV_VALID, 8'h81});
    send_frame(8'h81, 1'b1);
    wait_cyc(BIT);
    check("r81_pending", exp_q.size(), 32'd0);
    check("r81_data", {24'd0, data_out}, 32'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 with correct parity 1, then with wrong parity 0
    flip_par = 1'b0;
    exp_q.push_back('{EV_VALID, 8'h07});
    send_frame(8'h07, 1'b1);
    flip_par = 1'b1;
    exp_q.push_back('{EV_PERR, 8'h07});
    send_frame(8'h07, 1'b1);
    flip_par = 1'b0;
    wait_cyc(BIT);
    check("par_pending", exp_q.size(), 32'd0);
    check("par_data", {24'd0, data_out}, 32'h07);
`endif

    check("final_pending", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
